// File: rtl/logic_pkg.sv
// Shared definitions for the 4-bit logic datapath: data width and op encodings.
package logic_pkg;

  localparam int unsigned DATA_W = 4;

  typedef logic [1:0] op_t;

  localparam op_t OP_LOAD = 2'b00;
  localparam op_t OP_AND  = 2'b01;
  localparam op_t OP_OR   = 2'b10;
  localparam op_t OP_XOR  = 2'b11;

endpackage

// File: rtl/and_4b.sv
// Bitwise 4-bit AND logic unit.
module and_4b (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] y_o
);

  assign y_o = a_i & b_i;

endmodule

// File: rtl/logic_op_4b.sv
// Combinational op select: combines the held accumulator with an operand.
module logic_op_4b
  import logic_pkg::*;
(
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  op_t               in_op_i,
  output logic [DATA_W-1:0] result_o
);

  logic [DATA_W-1:0] and_res;

  and_4b u_and (
    .a_i (acc_i),
    .b_i (in_data_i),
    .y_o (and_res)
  );

  always_comb begin
    result_o = in_data_i;
    unique case (in_op_i)
      OP_LOAD: result_o = in_data_i;
      OP_AND:  result_o = and_res;
      OP_OR:   result_o = acc_i | in_data_i;
      OP_XOR:  result_o = acc_i ^ in_data_i;
      default: result_o = in_data_i;
    endcase
  end

endmodule

// File: rtl/logic_acc_4b.sv
// Registered 4-bit logic accumulator with a single-entry valid/ready output stage.
// Optional out_parity_o port is enabled by defining LOGIC_ACC_PARITY_EN.
module logic_acc_4b
  import logic_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  op_t               in_op_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_zero_o,
`ifdef LOGIC_ACC_PARITY_EN
  output logic              out_parity_o,
`endif
  output logic [CNT_W-1:0]  op_cnt_o
);

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  logic [0:0]        state_q, state_d;
  // Accumulator doubles as the output data register; they are always equal.
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result;
  logic              accept;

  logic_op_4b u_op (
    .acc_i     (acc_q),
    .in_data_i (in_data_i),
    .in_op_i   (in_op_i),
    .result_o  (result)
  );

  assign out_valid_o = (state_q == StFull);
  assign in_ready_o  = !clr_i && (!out_valid_o || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = StEmpty;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = StFull;
      acc_d   = result;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (state_q == StFull && out_ready_i) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data_o = acc_q;
  assign out_zero_o = (acc_q == '0);
  assign op_cnt_o   = cnt_q;

`ifdef LOGIC_ACC_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (clr_i) begin
      parity_d = 1'b0;
    end else if (accept) begin
      parity_d = ^result;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity_o = parity_q;
`endif

endmodule
